i2c_master_byte_control: RTL

Byte-level sequencer for the I2C master, sitting directly upstream of `master_bit_control`. It accepts one byte transaction at a time from the host side: optional START, write or read of 8 bits MSB-first with the ACK bit, optional STOP. It breaks each transaction into single-bit commands on the bit controller's `i_cmd`/`i_data_in` inputs and collects results from its `o_data_out`, using a one-cycle `done` handshake per bit.

---
 rtl/i2c_master_byte_control.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/i2c_master_byte_control.sv
// Byte-level I2C sequencer: splits START / 8-bit write+ACK or read+ACK / STOP into bit commands.
// Optional per-bit watchdog enabled by defining I2C_BYTE_TIMEOUT_EN.
`timescale 1ns/1ps
module i2c_master_byte_control #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic       i_clk_master,
    input  logic       i_reset,
    input  logic       i_cmd_valid,
    input  logic       i_start,
    input  logic       i_stop,
    input  logic       i_write,
    input  logic       i_read,
    input  logic       i_ack_in,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    output logic       o_ack_out,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_timeout,
    output logic [2:0] o_bit_cmd,
    output logic       o_bit_data,
    input  logic       i_bit_done,
    input  logic       i_bit_data
);

    localparam logic [2:0] CMD_IDLE  = 3'b000;
    localparam logic [2:0] CMD_START = 3'b001;
    localparam logic [2:0] CMD_WRITE = 3'b010;
    localparam logic [2:0] CMD_READ  = 3'b011;
    localparam logic [2:0] CMD_STOP  = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WRITE,
        ST_ACK_RD,
        ST_READ,
        ST_ACK_WR,
        ST_STOP
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] shift;
    logic [2:0] bit_cnt;
    logic       f_stop;
    logic       f_write;
    logic       f_read;
    logic       ack_l;
    logic       finish;
    logic       accept_empty;
    logic       timeout_hit;

    assign o_busy = (state != ST_IDLE);

`ifdef I2C_BYTE_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

    logic [TO_W-1:0] to_cnt;

    assign timeout_hit = (state != ST_IDLE) && (to_cnt == TO_LIMIT);

    // Counter restarts on every completed bit and on every state entry.
    always_ff @(posedge i_clk_master) begin
        if (!i_reset) begin
            to_cnt    <= '0;
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= timeout_hit;
            if (state_next == ST_IDLE || state_next != state || i_bit_done) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign o_timeout   = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge i_clk_master) begin
        if (!i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        o_bit_cmd    = CMD_IDLE;
        o_bit_data   = 1'b0;
        finish       = 1'b0;
        accept_empty = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    if (i_start) begin
                        state_next = ST_START;
                    end else if (i_write) begin
                        state_next = ST_WRITE;
                    end else if (i_read) begin
                        state_next = ST_READ;
                    end else if (i_stop) begin
                        state_next = ST_STOP;
                    end else begin
                        accept_empty = 1'b1;
                    end
                end
            end
            ST_START: begin
                o_bit_cmd = CMD_START;
                if (i_bit_done) begin
                    if (f_write) begin
                        state_next = ST_WRITE;
                    end else if (f_read) begin
                        state_next = ST_READ;
                    end else if (f_stop) begin
                        state_next = ST_STOP;
                    end else begin
                        state_next = ST_IDLE;
                        finish     = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                o_bit_cmd  = CMD_WRITE;
                o_bit_data = shift[7];
                if (i_bit_done && bit_cnt == 3'd7) begin
                    state_next = ST_ACK_RD;
                end
            end
            ST_READ: begin
                o_bit_cmd = CMD_READ;
                if (i_bit_done && bit_cnt == 3'd7) begin
                    state_next = ST_ACK_WR;
                end
            end
            ST_ACK_RD, ST_ACK_WR: begin
                o_bit_cmd  = (state == ST_ACK_RD) ? CMD_READ : CMD_WRITE;
                o_bit_data = (state == ST_ACK_WR) ? ack_l : 1'b0;
                if (i_bit_done) begin
                    if (f_stop) begin
                        state_next = ST_STOP;
                    end else begin
                        state_next = ST_IDLE;
                        finish     = 1'b1;
                    end
                end
            end
            ST_STOP: begin
                o_bit_cmd = CMD_STOP;
                if (i_bit_done) begin
                    state_next = ST_IDLE;
                    finish     = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // A watchdog abort overrides any normal advance and suppresses o_done.
        if (timeout_hit) begin
            state_next = ST_IDLE;
            finish     = 1'b0;
        end
    end

    always_ff @(posedge i_clk_master) begin
        if (!i_reset) begin
            shift     <= '0;
            bit_cnt   <= '0;
            f_stop    <= 1'b0;
            f_write   <= 1'b0;
            f_read    <= 1'b0;
            ack_l     <= 1'b0;
            o_data    <= '0;
            o_ack_out <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            o_done <= finish | accept_empty;
            case (state)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        shift   <= i_data;
                        bit_cnt <= '0;
                        f_stop  <= i_stop;
                        f_write <= i_write;
                        f_read  <= i_read;
                        ack_l   <= i_ack_in;
                    end
                end
                ST_WRITE: begin
                    if (i_bit_done) begin
                        shift   <= {shift[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                ST_ACK_RD: begin
                    if (i_bit_done) begin
                        o_ack_out <= i_bit_data;
                    end
                end
                ST_READ: begin
                    if (i_bit_done) begin
                        o_data  <= {o_data[6:0], i_bit_data};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
